// File: rtl/flu_wb_scheduler.sv
// Writeback-port scheduler for the shared fixed-latency units: reserves future
// writeback slots, gates issue on slot availability and drives the writeback mux.
module flu_wb_scheduler #(
   parameter int unsigned MulLatency  = 1,
   parameter int unsigned SlotDepth   = 4,
   parameter int unsigned TransIdBits = 3
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic                   issue_valid_i,
   input  logic [1:0]             issue_fu_i,
   input  logic [TransIdBits-1:0] issue_trans_id_i,
   output logic                   issue_ready_o,
   input  logic                   csr_commit_i,
   input  logic                   div_done_i,
   output logic                   wb_valid_o,
   output logic [1:0]             wb_sel_o,
   output logic [TransIdBits-1:0] wb_trans_id_o,
   output logic                   csr_busy_o,
   output logic                   div_busy_o,
   output logic [15:0]            stall_cnt_o
);

   localparam logic [1:0] FuAlu = 2'd0;
   localparam logic [1:0] FuCsr = 2'd1;
   localparam logic [1:0] FuMul = 2'd2;
   localparam logic [1:0] FuDiv = 2'd3;

   if ((MulLatency < 1) || (MulLatency >= SlotDepth)) begin : g_bad_mul_latency
      $fatal(1, "flu_wb_scheduler: MulLatency must be in 1..SlotDepth-1");
   end

   logic [SlotDepth-1:0]                  slot_valid_q, slot_valid_d;
   logic [SlotDepth-1:0][1:0]             slot_fu_q, slot_fu_d;
   logic [SlotDepth-1:0][TransIdBits-1:0] slot_id_q, slot_id_d;
   logic                                  csr_busy_q, csr_busy_d;
   logic                                  div_busy_q, div_busy_d;
   logic [TransIdBits-1:0]                div_id_q, div_id_d;
   logic [15:0]                           stall_cnt_q, stall_cnt_d;

   logic fire;

   // A request may only fire if the slot its result will occupy is still free.
   always_comb begin
      issue_ready_o = 1'b0;
      if (!flush_i && !div_busy_q) begin
         case (issue_fu_i)
            FuAlu:   issue_ready_o = !slot_valid_q[0];
            FuCsr:   issue_ready_o = !slot_valid_q[0] && !csr_busy_q;
            FuMul:   issue_ready_o = !slot_valid_q[MulLatency];
            default: issue_ready_o = (slot_valid_q == '0);
         endcase
      end
   end

   assign fire = issue_valid_i & issue_ready_o;

   always_comb begin
      slot_valid_d = '0;
      slot_fu_d    = '0;
      slot_id_d    = '0;
      for (int unsigned k = 0; k < SlotDepth - 1; k++) begin
         slot_valid_d[k] = slot_valid_q[k+1];
         slot_fu_d[k]    = slot_fu_q[k+1];
         slot_id_d[k]    = slot_id_q[k+1];
      end
      if (fire && (issue_fu_i == FuMul)) begin
         slot_valid_d[MulLatency-1] = 1'b1;
         slot_fu_d[MulLatency-1]    = FuMul;
         slot_id_d[MulLatency-1]    = issue_trans_id_i;
      end
      if (flush_i) begin
         slot_valid_d = '0;
      end
   end

   always_comb begin
      csr_busy_d  = csr_busy_q;
      div_busy_d  = div_busy_q;
      div_id_d    = div_id_q;
      stall_cnt_d = stall_cnt_q;
      if (csr_commit_i) begin
         csr_busy_d = 1'b0;
      end
      if (fire && (issue_fu_i == FuCsr)) begin
         csr_busy_d = 1'b1;
      end
      if (div_done_i && div_busy_q) begin
         div_busy_d = 1'b0;
      end
      if (fire && (issue_fu_i == FuDiv)) begin
         div_busy_d = 1'b1;
         div_id_d   = issue_trans_id_i;
      end
      if (flush_i) begin
         csr_busy_d = 1'b0;
         div_busy_d = 1'b0;
      end
      if (issue_valid_i && !issue_ready_o && !flush_i && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // Sources never overlap by construction; the priority only guards odd inputs.
   always_comb begin
      wb_valid_o    = 1'b0;
      wb_sel_o      = FuAlu;
      wb_trans_id_o = '0;
      if (!flush_i) begin
         if (div_done_i && div_busy_q) begin
            wb_valid_o    = 1'b1;
            wb_sel_o      = FuDiv;
            wb_trans_id_o = div_id_q;
         end else if (slot_valid_q[0]) begin
            wb_valid_o    = 1'b1;
            wb_sel_o      = slot_fu_q[0];
            wb_trans_id_o = slot_id_q[0];
         end else if (fire && ((issue_fu_i == FuAlu) || (issue_fu_i == FuCsr))) begin
            wb_valid_o    = 1'b1;
            wb_sel_o      = issue_fu_i;
            wb_trans_id_o = issue_trans_id_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_valid_q <= '0;
         slot_fu_q    <= '0;
         slot_id_q    <= '0;
         csr_busy_q   <= 1'b0;
         div_busy_q   <= 1'b0;
         div_id_q     <= '0;
         stall_cnt_q  <= '0;
      end else begin
         slot_valid_q <= slot_valid_d;
         slot_fu_q    <= slot_fu_d;
         slot_id_q    <= slot_id_d;
         csr_busy_q   <= csr_busy_d;
         div_busy_q   <= div_busy_d;
         div_id_q     <= div_id_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign csr_busy_o  = csr_busy_q;
   assign div_busy_o  = div_busy_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_flu_wb_scheduler.sv
// Bench for flu_wb_scheduler: directed scenarios followed by random traffic,
// all checked against a cycle-indexed reservation model.
module tb_flu_wb_scheduler;

   localparam int MulLat = 2;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       flush_i;
   logic       issue_valid_i;
   logic [1:0] issue_fu_i;
   logic [2:0] issue_trans_id_i;
   logic       issue_ready_o;
   logic       csr_commit_i;
   logic       div_done_i;
   logic       wb_valid_o;
   logic [1:0] wb_sel_o;
   logic [2:0] wb_trans_id_o;
   logic       csr_busy_o;
   logic       div_busy_o;
   logic [15:0] stall_cnt_o;

   flu_wb_scheduler #(
      .MulLatency  (MulLat),
      .SlotDepth   (4),
      .TransIdBits (3)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .flush_i          (flush_i),
      .issue_valid_i    (issue_valid_i),
      .issue_fu_i       (issue_fu_i),
      .issue_trans_id_i (issue_trans_id_i),
      .issue_ready_o    (issue_ready_o),
      .csr_commit_i     (csr_commit_i),
      .div_done_i       (div_done_i),
      .wb_valid_o       (wb_valid_o),
      .wb_sel_o         (wb_sel_o),
      .wb_trans_id_o    (wb_trans_id_o),
      .csr_busy_o       (csr_busy_o),
      .div_busy_o       (div_busy_o),
      .stall_cnt_o      (stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Model: multiplier results booked by the absolute cycle they return in.
   int unsigned mul_due[int];
   int          cyc;
   bit          m_csr_busy;
   bit          m_div_busy;
   int unsigned m_div_id;
   int unsigned m_stall;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, actual, expected);
      end
   endtask

   task automatic resetModel();
      mul_due.delete();
      m_csr_busy = 1'b0;
      m_div_busy = 1'b0;
      m_div_id   = 0;
      m_stall    = 0;
   endtask

   // One cycle: drive on the falling edge, check before the rising edge, then advance the model.
   task automatic applyStimulus(input bit v, input bit [1:0] fu, input bit [2:0] id,
                                input bit fl, input bit commit, input bit done);
      bit          exp_ready;
      bit          exp_fire;
      bit          exp_wbv;
      int unsigned exp_sel;
      int unsigned exp_id;
      @(negedge clk_i);
      issue_valid_i    = v;
      issue_fu_i       = fu;
      issue_trans_id_i = id;
      flush_i          = fl;
      csr_commit_i     = commit;
      div_done_i       = done;
      #2;
      exp_ready = 1'b0;
      if (!fl && !m_div_busy) begin
         case (fu)
            2'd0: exp_ready = !mul_due.exists(cyc);
            2'd1: exp_ready = !mul_due.exists(cyc) && !m_csr_busy;
            2'd2: exp_ready = !mul_due.exists(cyc + MulLat);
            default: exp_ready = (mul_due.num() == 0);
         endcase
      end
      exp_fire = v && exp_ready;
      exp_wbv  = 1'b0;
      exp_sel  = 0;
      exp_id   = 0;
      if (!fl) begin
         if (done && m_div_busy) begin
            exp_wbv = 1'b1; exp_sel = 3; exp_id = m_div_id;
         end else if (mul_due.exists(cyc)) begin
            exp_wbv = 1'b1; exp_sel = 2; exp_id = mul_due[cyc];
         end else if (exp_fire && (fu < 2)) begin
            exp_wbv = 1'b1; exp_sel = fu; exp_id = id;
         end
      end
      checkOutput("issue_ready", {31'd0, issue_ready_o}, {31'd0, exp_ready});
      checkOutput("wb_valid", {31'd0, wb_valid_o}, {31'd0, exp_wbv});
      checkOutput("wb_sel", {30'd0, wb_sel_o}, exp_sel);
      checkOutput("wb_trans_id", {29'd0, wb_trans_id_o}, exp_id);
      checkOutput("csr_busy", {31'd0, csr_busy_o}, {31'd0, m_csr_busy});
      checkOutput("div_busy", {31'd0, div_busy_o}, {31'd0, m_div_busy});
      checkOutput("stall_cnt", {16'd0, stall_cnt_o}, m_stall);

      if (v && !exp_ready && !fl && (m_stall != 65535)) m_stall++;
      mul_due.delete(cyc);
      if (fl) begin
         mul_due.delete();
         m_csr_busy = 1'b0;
         m_div_busy = 1'b0;
      end else begin
         if (exp_fire && (fu == 2)) mul_due[cyc + MulLat] = id;
         if (commit) m_csr_busy = 1'b0;
         if (exp_fire && (fu == 1)) m_csr_busy = 1'b1;
         if (done && m_div_busy) m_div_busy = 1'b0;
         if (exp_fire && (fu == 3)) begin
            m_div_busy = 1'b1;
            m_div_id   = id;
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      cyc = 0;
      resetModel();
      rst_ni           = 1'b0;
      flush_i          = 1'b0;
      issue_valid_i    = 1'b0;
      issue_fu_i       = 2'd0;
      issue_trans_id_i = 3'd0;
      csr_commit_i     = 1'b0;
      div_done_i       = 1'b0;
      idle(2);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // ALU writes back in its issue cycle
      applyStimulus(1'b1, 2'd0, 3'd4, 1'b0, 1'b0, 1'b0);
      checkOutput("t1_wb_id", {29'd0, wb_trans_id_o}, 32'd4);
      idle(1);

      // MUL followed by a held ALU request
      applyStimulus(1'b1, 2'd2, 3'd5, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd0, 3'd1, 1'b0, 1'b0, 1'b0);
      idle(3);

      // Back-to-back MULs
      for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 2'd2, 3'(i), 1'b0, 1'b0, 1'b0);
      idle(4);

      // DIV blocks everything until done
      applyStimulus(1'b1, 2'd3, 3'd6, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 2'd0, 3'd2, 1'b0, 1'b0, i == 10);
      applyStimulus(1'b1, 2'd0, 3'd2, 1'b0, 1'b0, 1'b0);
      idle(2);

      // CSR buffer occupancy
      applyStimulus(1'b1, 2'd1, 3'd2, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd1, 3'd3, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd0, 3'd1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd1, 3'd3, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'd1, 3'd3, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0);
      idle(1);

      // Flush drops an in-flight MUL
      applyStimulus(1'b1, 2'd2, 3'd7, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd0, 3'd5, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'd0, 3'd5, 1'b0, 1'b0, 1'b0);
      idle(2);

      for (int i = 0; i < 3000; i++) begin
         applyStimulus($urandom_range(0, 99) < 65, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                       $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 20);
      end

      // Asynchronous reset in the middle of a cycle
      @(negedge clk_i);
      issue_valid_i = 1'b0;
      flush_i       = 1'b0;
      csr_commit_i  = 1'b0;
      div_done_i    = 1'b0;
      #2;
      rst_ni = 1'b0;
      #1;
      checkOutput("rst_csr_busy", {31'd0, csr_busy_o}, 32'd0);
      checkOutput("rst_div_busy", {31'd0, div_busy_o}, 32'd0);
      checkOutput("rst_stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
      checkOutput("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
      resetModel();
      @(negedge clk_i);
      rst_ni = 1'b1;
      applyStimulus(1'b1, 2'd3, 3'd5, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1);
      idle(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
      $finish;
   end

endmodule
